// File: rtl/interp_curve_table_if.sv
// interp_curve_table_if: request, table-write and result signals of the interpolated curve lookup
interface interp_curve_table_if #(
  parameter int IDX_W = 7,
  parameter int FRAC_W = 15,
  parameter int ENT_W = 7,
  parameter int OUT_FRAC_W = 6,
  parameter int TAG_W = 5
);
  logic clkena;
  logic in_valid;
  logic [TAG_W-1:0] in_tag;
  logic [IDX_W+FRAC_W-1:0] addr;
  logic wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [ENT_W-1:0] wr_data;
  logic out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [ENT_W+OUT_FRAC_W-1:0] data;
  modport master (
    output clkena, in_valid, in_tag, addr, wr_en, wr_idx, wr_data,
    input out_valid, out_tag, data
  );
  modport slave (
    input clkena, in_valid, in_tag, addr, wr_en, wr_idx, wr_data,
    output out_valid, out_tag, data
  );
endinterface

// File: rtl/interp_curve_table.sv
// interp_curve_table: 3-stage linearly interpolated curve lookup; INTERP_CURVE_ROUND_EN enables round-half-up
module interp_curve_table #(
  parameter int IDX_W = 7,
  parameter int FRAC_W = 15,
  parameter int WGT_W = 8,
  parameter int ENT_W = 7,
  parameter int OUT_FRAC_W = 6,
  parameter int TAG_W = 5,
  parameter INIT_FILE = "attack_curve.hex"
) (
  input logic clk,
  input logic reset,
  interp_curve_table_if.slave bus
);
  localparam int DEPTH = 2**IDX_W;
  localparam int OW = ENT_W + OUT_FRAC_W;
  localparam int SH = WGT_W - OUT_FRAC_W;
  localparam int PW = WGT_W + ENT_W + 2;
`ifdef INTERP_CURVE_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'((2**SH) / 2);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif
  function automatic logic [DEPTH-1:0][ENT_W-1:0] attack_curve();
    int v;
    for (int i = 0; i < DEPTH; i++) begin
      v = (i == DEPTH - 1) ? 2**ENT_W - 1 : (i * i + 30 * i) / 168;
      attack_curve[i] = ENT_W'((v > 2**ENT_W - 1) ? 2**ENT_W - 1 : v);
    end
  endfunction
  // the attack curve image is built in; any other image name starts blank and is loaded by writes
  logic [DEPTH-1:0][ENT_W-1:0] tbl = (INIT_FILE == "attack_curve.hex") ? attack_curve() : '0;
  logic [IDX_W-1:0] idx, nxt;
  logic v1, v2;
  logic [TAG_W-1:0] t1, t2;
  logic [ENT_W-1:0] d1, d2, e2;
  logic [WGT_W-1:0] w1;
  logic [OW-1:0] p2;
  logic signed [ENT_W:0] diff;
  logic signed [PW-1:0] prod;
  logic unused_frac;
  assign idx = bus.addr[IDX_W+FRAC_W-1:FRAC_W];
  assign nxt = &idx ? idx : idx + 1'b1;
  assign unused_frac = ^bus.addr[FRAC_W-WGT_W-1:0];
  always_comb begin
    diff = $signed({1'b0, d2}) - $signed({1'b0, d1});
    prod = $signed({1'b0, w1}) * diff;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      t1 <= '0;
      d1 <= '0;
      d2 <= '0;
      w1 <= '0;
      v2 <= 1'b0;
      t2 <= '0;
      e2 <= '0;
      p2 <= '0;
      bus.out_valid <= 1'b0;
      bus.out_tag <= '0;
      bus.data <= '0;
    end else if (bus.clkena) begin
      v1 <= bus.in_valid;
      t1 <= bus.in_tag;
      d1 <= tbl[idx];
      d2 <= tbl[nxt];
      w1 <= bus.addr[FRAC_W-1 -: WGT_W];
      v2 <= v1;
      t2 <= t1;
      e2 <= d1;
      p2 <= OW'((prod + RND) >>> SH);
      bus.out_valid <= v2;
      bus.out_tag <= t2;
      bus.data <= (OW'(e2) << OUT_FRAC_W) + p2;
    end
  end
  always_ff @(posedge clk) begin
    if (bus.wr_en && !reset) tbl[bus.wr_idx] <= bus.wr_data;
  end
endmodule

// File: tb/tb_interp_curve_table.sv
// tb_interp_curve_table: randomized scoreboard bench with directed curve cases
module tb_interp_curve_table;
  localparam int IDX_W = 7, FRAC_W = 15, WGT_W = 8, ENT_W = 7, OUT_FRAC_W = 6, TAG_W = 5;
  localparam int DEPTH = 2**IDX_W;
  localparam int SH = WGT_W - OUT_FRAC_W;
`ifdef INTERP_CURVE_ROUND_EN
  localparam int RND = (2**SH) / 2;
  localparam int LIT4 = 1;
`else
  localparam int RND = 0;
  localparam int LIT4 = 0;
`endif
  typedef struct {int tag; int data;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  interp_curve_table_if #(.IDX_W(IDX_W), .FRAC_W(FRAC_W), .ENT_W(ENT_W), .OUT_FRAC_W(OUT_FRAC_W), .TAG_W(TAG_W)) bus ();
  interp_curve_table dut (.clk(clk), .reset(reset), .bus(bus));
  exp_t q[$];
  int model_tbl[DEPTH];
  int vectors = 0;
  int miscompares = 0;
  int lit = -1;
  task automatic check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  function automatic int ref_level(int i, int w);
    int a, b;
    a = model_tbl[i];
    b = (i == DEPTH - 1) ? a : model_tbl[i + 1];
    return a * (2**OUT_FRAC_W) + ((w * (b - a) + RND) >>> SH);
  endfunction
  always @(posedge clk) begin
    if (reset) q.delete();
    else begin
      if (bus.clkena && bus.in_valid)
        q.push_back('{int'(bus.in_tag),
                      (lit >= 0) ? lit : ref_level(int'(bus.addr[IDX_W+FRAC_W-1:FRAC_W]), int'(bus.addr[FRAC_W-1 -: WGT_W]))});
      if (bus.wr_en) model_tbl[bus.wr_idx] = int'(bus.wr_data);
    end
  end
  logic pv;
  int pt, pd;
  always @(posedge clk) begin : monitor
    logic en_s, rst_s;
    exp_t e;
    en_s = bus.clkena;
    rst_s = reset;
    #1;
    if (rst_s) begin
      check("reset_valid", int'(bus.out_valid), 0);
      check("reset_tag", int'(bus.out_tag), 0);
      check("reset_data", int'(bus.data), 0);
    end else if (!en_s) begin
      check("hold_valid", int'(bus.out_valid), int'(pv));
      check("hold_tag", int'(bus.out_tag), pt);
      check("hold_data", int'(bus.data), pd);
    end else if (bus.out_valid) begin
      if (q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        check("tag", int'(bus.out_tag), e.tag);
        check("data", int'(bus.data), e.data);
      end
    end
    pv = bus.out_valid;
    pt = int'(bus.out_tag);
    pd = int'(bus.data);
  end
  task automatic drive(bit en, bit v, int tag, int idx, int w, bit we, int widx, int wd, int l);
    @(negedge clk);
    bus.clkena = en;
    bus.in_valid = v;
    bus.in_tag = TAG_W'(tag);
    bus.addr = {IDX_W'(idx), WGT_W'(w), 7'($urandom)};
    bus.wr_en = we;
    bus.wr_idx = IDX_W'(widx);
    bus.wr_data = ENT_W'(wd);
    lit = l;
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = (i == DEPTH - 1) ? 127 : (i * i + 30 * i) / 168;
    bus.clkena = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_tag = '0;
    bus.addr = '0;
    bus.wr_en = 1'b0;
    bus.wr_idx = '0;
    bus.wr_data = '0;
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, -1);
    reset = 1'b0;
    drive(1, 1, 3, 126, 'h80, 0, 0, 0, 7808);
    drive(1, 1, 7, 127, 'hFF, 0, 0, 0, 8128);
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 4, 4, 3, 0, 0, 0, LIT4);
    drive(1, 0, 0, 0, 0, 1, 5, 100, -1);
    drive(1, 0, 0, 0, 0, 1, 6, 20, -1);
    drive(1, 1, 11, 5, 'h40, 0, 0, 0, 5120);
    drive(1, 1, 12, 5, 0, 1, 5, 50, 6400);
    drive(1, 1, 13, 5, 0, 0, 0, 0, 3200);
    for (int k = 0; k < 8; k++) drive(k % 2 == 0, 1, 20 + k, 10 + k, $urandom_range(255), 0, 0, 0, -1);
    repeat (4) drive(1, 0, 0, 0, 0, 0, 0, 0, -1);
    drive(1, 1, 1, 30, 0, 0, 0, 0, -1);
    drive(1, 1, 2, 31, 0, 0, 0, 0, -1);
    drive(1, 1, 5, 40, 0, 1, 6, 99, -1);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, -1);
    reset = 1'b0;
    drive(1, 1, 6, 5, 0, 0, 0, 0, 3200);
    drive(1, 1, 7, 6, 0, 0, 0, 0, 1280);
    repeat (400) begin
      drive($urandom_range(3) != 0, 1'($urandom_range(1)), int'($urandom_range(31)), int'($urandom_range(127)),
            int'($urandom_range(255)), $urandom_range(4) == 0, int'($urandom_range(127)), int'($urandom_range(127)), -1);
      reset = ($urandom_range(99) == 0);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, -1);
    reset = 1'b0;
    repeat (5) drive(1, 0, 0, 0, 0, 0, 0, 0, -1);
    @(posedge clk);
    #2;
    check("drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
